// File: rtl/sram_wide_controller.sv
// sram_wide_controller: moves one DATA_W-bit CPU word to or from a 16-bit
// asynchronous SRAM as DATA_W/16 consecutive half-word beats. Request address
// and data are latched at accept. A programmable settle interval follows the
// last beat. Out-of-window or misaligned requests are rejected without any
// SRAM cycle.
module sram_wide_controller #(
  parameter int          DATA_W    = 32,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int          SRAM_AW   = 18,
  parameter int          SETTLE    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic                rdEn,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   writeData,
  output logic [DATA_W-1:0]   readData,
  output logic                ready,
  output logic                err,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  localparam int WORDS   = DATA_W / 16;
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int WSH     = $clog2(WORDS);
  // A 16-bit build has a single beat; keep a 1-bit counter that stays at 0.
  localparam int KW      = (WSH > 0) ? WSH : 1;

  localparam logic [31:0]   ALIGN_MASK  = 32'((1 << BYTE_SH) - 1);
  localparam logic [63:0]   HW_LIMIT    = 64'd1 << (SRAM_AW - WSH);
  localparam logic [KW-1:0] LAST_BEAT   = KW'(WORDS - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RADDR,
    RDATA,
    STALL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]     k_q;
  logic [3:0]        s_q;
  logic [31:0]       aq;
  logic [DATA_W-1:0] wq;
  logic              op_wr_q;
  logic              eq_q;
  logic [DATA_W-1:0] shadow_q;

  logic [31:0] req_off;
  logic [63:0] req_hw;
  logic        req_any;
  logic        req_reject;

  logic [31:0] k_ext;
  logic [31:0] acc_off;
  logic [31:0] beat_addr;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        last_beat;

  // Qualify the incoming request against the SRAM window and word alignment.
  always_comb begin
    req_off    = address - BASE_ADDR;
    req_hw     = 64'(req_off) >> BYTE_SH;
    req_any    = wrEn | rdEn;
    req_reject = (address < BASE_ADDR) ||
                 ((req_off & ALIGN_MASK) != '0) ||
                 (req_hw >= HW_LIMIT);
  end

  // Half-word address and write beat for the current beat index.
  always_comb begin
    k_ext     = 32'(k_q);
    acc_off   = aq - BASE_ADDR;
    beat_addr = ((acc_off >> BYTE_SH) << WSH) | k_ext;
    dq_out    = wq[k_ext*16 +: 16];
    last_beat = (k_q == LAST_BEAT);
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and SRAM/handshake outputs.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    err       = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req_any;
        if (req_any) begin
          if (req_reject) state_d = DONE;
          else if (wrEn)  state_d = WRITE;
          else            state_d = RADDR;
        end
      end
      WRITE: begin
        SRAM_WE_N = 1'b0;
        SRAM_ADDR = SRAM_AW'(beat_addr);
        dq_oe     = 1'b1;
        if (last_beat) state_d = STALL;
      end
      RADDR: begin
        SRAM_ADDR = SRAM_AW'(beat_addr);
        state_d   = RDATA;
      end
      RDATA: begin
        SRAM_ADDR = SRAM_AW'(beat_addr);
        state_d   = last_beat ? STALL : RADDR;
      end
      STALL: begin
        if (s_q == SETTLE_LAST) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        err     = eq_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset acts in the current cycle: bus released, handshake as in IDLE.
    if (rst) begin
      state_d   = IDLE;
      ready     = ~req_any;
      err       = 1'b0;
      SRAM_WE_N = 1'b1;
      SRAM_ADDR = '0;
      dq_oe     = 1'b0;
    end
  end

  // Request latches, beat/settle counters, read shadow and readData.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      s_q      <= '0;
      aq       <= '0;
      wq       <= '0;
      op_wr_q  <= 1'b0;
      eq_q     <= 1'b0;
      shadow_q <= '0;
      readData <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            aq      <= address;
            wq      <= writeData;
            op_wr_q <= wrEn;
            eq_q    <= req_reject;
            k_q     <= '0;
            s_q     <= '0;
          end
        end
        WRITE: begin
          if (!last_beat) k_q <= k_q + KW'(1);
        end
        RDATA: begin
          shadow_q[k_ext*16 +: 16] <= SRAM_DQ;
          if (!last_beat) k_q <= k_q + KW'(1);
        end
        STALL: begin
          s_q <= s_q + 4'd1;
          // Publish on the DONE-entry edge so readData is valid throughout DONE.
          if (s_q == SETTLE_LAST && !op_wr_q && !eq_q) readData <= shadow_q;
        end
        DONE: begin
          eq_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wide_controller.sv
// Directed bench for sram_wide_controller: default 32-bit build plus a 64-bit,
// SETTLE=1 build, each attached to a small behavioural SRAM.
module tb_sram_wide_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst = 1'b1;

  logic        wrEn0 = 1'b0, rdEn0 = 1'b0;
  logic [31:0] address0 = '0, wd0 = '0;
  logic [31:0] rd0;
  logic        ready0, err0;
  wire  [15:0] dq0;
  logic [17:0] sa0;
  logic        we0_n, ub0, lb0, ce0, oe0;

  logic        wrEn1 = 1'b0, rdEn1 = 1'b0;
  logic [31:0] address1 = '0;
  logic [63:0] wd1 = '0;
  logic [63:0] rd1;
  logic        ready1, err1;
  wire  [15:0] dq1;
  logic [17:0] sa1;
  logic        we1_n, ub1, lb1, ce1, oe1;

  logic        sram_en0 = 1'b0, sram_en1 = 1'b0;
  logic [15:0] mem0 [0:4095];
  logic [15:0] mem1 [0:15];

  sram_wide_controller #(.DATA_W(32), .BASE_ADDR(1024), .SRAM_AW(18), .SETTLE(3)) dut0 (
    .clk(clk), .rst(rst), .wrEn(wrEn0), .rdEn(rdEn0), .address(address0),
    .writeData(wd0), .readData(rd0), .ready(ready0), .err(err0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0_n), .SRAM_UB_N(ub0),
    .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
  );

  sram_wide_controller #(.DATA_W(64), .BASE_ADDR(1024), .SRAM_AW(18), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .wrEn(wrEn1), .rdEn(rdEn1), .address(address1),
    .writeData(wd1), .readData(rd1), .ready(ready1), .err(err1),
    .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1_n), .SRAM_UB_N(ub1),
    .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  // SRAM models: drive stored data (or a sentinel) whenever WE_N is high.
  assign dq0 = we0_n ? (sram_en0 ? mem0[sa0[11:0]] : 16'hA5A5) : 16'hzzzz;
  assign dq1 = we1_n ? (sram_en1 ? mem1[sa1[3:0]] : 16'hA5A5) : 16'hzzzz;

  always @(posedge clk) if (!we0_n) mem0[sa0[11:0]] <= dq0;
  always @(posedge clk) if (!we1_n) mem1[sa1[3:0]] <= dq1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) mem0[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem1[i] = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd0 got %h exp %h", rd0, 32'h0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b exp 0", err0); end
    checks++; if (we0_n !== 1'b1) begin errors++; $display("FAIL reset_we0 got %b exp 1", we0_n); end
    checks++; if (sa0 !== 18'h0) begin errors++; $display("FAIL reset_addr0 got %h exp 0", sa0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", ready0); end
    checks++; if (dq0 !== 16'hA5A5) begin errors++; $display("FAIL reset_dq0 got %h exp a5a5", dq0); end
    checks++; if ({ub0, lb0, ce0, oe0} !== 4'b0000) begin errors++; $display("FAIL reset_ties got %b exp 0000", {ub0, lb0, ce0, oe0}); end
    checks++; if (rd1 !== 64'h0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", rd1); end
    checks++; if ({ready1, we1_n, ub1, lb1, ce1, oe1} !== 6'b110000) begin errors++; $display("FAIL reset_dut1 got %b exp 110000", {ready1, we1_n, ub1, lb1, ce1, oe1}); end
    rdEn0 = 1'b1;
    #1;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready_req got %b exp 0", ready0); end
    rdEn0 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_default();
    logic       exp_ready, exp_we;
    sram_en0 = 1'b0;
    wrEn0 = 1'b1; address0 = 32'h1000; wd0 = 32'hDEADBEEF;
    #1;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL wr_c0_ready got %b exp 0", ready0); end
    tick();
    wrEn0 = 1'b0; address0 = 32'h2000; wd0 = 32'h0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      exp_ready = (c >= 6);
      exp_we    = (c > 2);
      checks++; if (ready0 !== exp_ready) begin errors++; $display("FAIL wr_ready c%0d got %b exp %b", c, ready0, exp_ready); end
      checks++; if (we0_n !== exp_we) begin errors++; $display("FAIL wr_we c%0d got %b exp %b", c, we0_n, exp_we); end
      if (c == 1) begin
        checks++; if (sa0 !== 18'h600 || dq0 !== 16'hBEEF) begin errors++; $display("FAIL wr_beat0 got %h/%h exp 600/beef", sa0, dq0); end
      end
      if (c == 2) begin
        checks++; if (sa0 !== 18'h601 || dq0 !== 16'hDEAD) begin errors++; $display("FAIL wr_beat1 got %h/%h exp 601/dead", sa0, dq0); end
      end
      if (c >= 3 && c <= 5) begin
        checks++; if (dq0 !== 16'hA5A5) begin errors++; $display("FAIL wr_stall_dq c%0d got %h exp a5a5", c, dq0); end
      end
      if (c == 6) begin
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL wr_done_err got %b exp 0", err0); end
      end
    end
    checks++; if (mem0[12'h600] !== 16'hBEEF || mem0[12'h601] !== 16'hDEAD) begin errors++; $display("FAIL wr_mem got %h %h exp beef dead", mem0[12'h600], mem0[12'h601]); end
  endtask

  task automatic test_read_default();
    logic [17:0] exp_sa;
    sram_en0 = 1'b1;
    rdEn0 = 1'b1; address0 = 32'h1000;
    #1;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rd_c0_ready got %b exp 0", ready0); end
    tick();
    rdEn0 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      checks++; if (ready0 !== (c >= 8)) begin errors++; $display("FAIL rd_ready c%0d got %b", c, ready0); end
      checks++; if (we0_n !== 1'b1) begin errors++; $display("FAIL rd_we c%0d got %b exp 1", c, we0_n); end
      if (c <= 4) begin
        exp_sa = (c <= 2) ? 18'h600 : 18'h601;
        checks++; if (sa0 !== exp_sa) begin errors++; $display("FAIL rd_addr c%0d got %h exp %h", c, sa0, exp_sa); end
      end
      if (c == 7) begin
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rd_early got %h exp 0", rd0); end
      end
      if (c == 8) begin
        checks++; if (rd0 !== 32'hDEADBEEF || err0 !== 1'b0) begin errors++; $display("FAIL rd_data got %h err %b exp deadbeef err 0", rd0, err0); end
      end
    end
  endtask

  task automatic test_wide64();
    logic [15:0] beats [4];
    beats[0] = 16'hCDEF; beats[1] = 16'h89AB; beats[2] = 16'h4567; beats[3] = 16'h0123;
    sram_en1 = 1'b0;
    wrEn1 = 1'b1; address1 = 32'd1032; wd1 = 64'h0123456789ABCDEF;
    tick();
    wrEn1 = 1'b0; wd1 = 64'h0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      checks++; if (ready1 !== (c >= 6)) begin errors++; $display("FAIL w64_ready c%0d got %b", c, ready1); end
      checks++; if (we1_n !== (c > 4)) begin errors++; $display("FAIL w64_we c%0d got %b", c, we1_n); end
      if (c <= 4) begin
        checks++; if (sa1 !== 18'(c + 3) || dq1 !== beats[c-1]) begin errors++; $display("FAIL w64_beat c%0d got %h/%h exp %h/%h", c, sa1, dq1, 18'(c + 3), beats[c-1]); end
      end
    end
    sram_en1 = 1'b1;
    rdEn1 = 1'b1;
    tick();
    rdEn1 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      checks++; if (ready1 !== (c >= 10)) begin errors++; $display("FAIL r64_ready c%0d got %b", c, ready1); end
      if (c <= 8) begin
        checks++; if (sa1 !== 18'(4 + (c - 1) / 2)) begin errors++; $display("FAIL r64_addr c%0d got %h", c, sa1); end
      end
      if (c == 9) begin
        checks++; if (rd1 !== 64'h0) begin errors++; $display("FAIL r64_early got %h exp 0", rd1); end
      end
      if (c == 10) begin
        checks++; if (rd1 !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL r64_data got %h exp 0123456789abcdef", rd1); end
      end
    end
  endtask

  task automatic test_reject();
    logic [31:0] addrs [3];
    logic        wr    [3];
    addrs[0] = 32'd1020;   wr[0] = 1'b1;
    addrs[1] = 32'd1026;   wr[1] = 1'b0;
    addrs[2] = 32'd525312; wr[2] = 1'b1;
    for (int v = 0; v < 3; v++) begin
      wrEn0 = wr[v]; rdEn0 = ~wr[v]; address0 = addrs[v];
      tick();
      wrEn0 = 1'b0; rdEn0 = 1'b0;
      checks++; if ({ready0, err0, we0_n} !== 3'b111) begin errors++; $display("FAIL rej%0d_c1 ready/err/we got %b exp 111", v, {ready0, err0, we0_n}); end
      checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rej%0d_rd got %h exp deadbeef", v, rd0); end
      tick();
      checks++; if ({ready0, err0, we0_n} !== 3'b101) begin errors++; $display("FAIL rej%0d_c2 ready/err/we got %b exp 101", v, {ready0, err0, we0_n}); end
    end
  endtask

  task automatic test_addr_boundary();
    sram_en0 = 1'b0;
    wrEn0 = 1'b1; address0 = 32'd525308; wd0 = 32'h12345678;
    tick();
    wrEn0 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      checks++; if (ready0 !== (c == 6)) begin errors++; $display("FAIL bnd_ready c%0d got %b", c, ready0); end
      if (c == 1) begin
        checks++; if (sa0 !== 18'h3FFFE || we0_n !== 1'b0 || dq0 !== 16'h5678) begin errors++; $display("FAIL bnd_beat0 got %h/%b/%h", sa0, we0_n, dq0); end
      end
      if (c == 2) begin
        checks++; if (sa0 !== 18'h3FFFF || dq0 !== 16'h1234) begin errors++; $display("FAIL bnd_beat1 got %h/%h", sa0, dq0); end
      end
      if (c == 6) begin
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL bnd_err got %b exp 0", err0); end
      end
    end
    tick();
  endtask

  task automatic test_priority();
    sram_en0 = 1'b0;
    wrEn0 = 1'b1; rdEn0 = 1'b1; address0 = 32'h1008; wd0 = 32'hCAFEF00D;
    tick();
    wrEn0 = 1'b0; rdEn0 = 1'b0; address0 = 32'h2000; wd0 = 32'h11111111;
    checks++; if (we0_n !== 1'b0 || sa0 !== 18'h604 || dq0 !== 16'hF00D) begin errors++; $display("FAIL pri_beat0 got %b/%h/%h exp 0/604/f00d", we0_n, sa0, dq0); end
    tick();
    checks++; if (we0_n !== 1'b0 || sa0 !== 18'h605 || dq0 !== 16'hCAFE) begin errors++; $display("FAIL pri_beat1 got %b/%h/%h exp 0/605/cafe", we0_n, sa0, dq0); end
    for (int c = 3; c <= 7; c++) begin
      tick();
      checks++; if (ready0 !== (c >= 6)) begin errors++; $display("FAIL pri_ready c%0d got %b", c, ready0); end
    end
  endtask

  task automatic test_back_to_back();
    sram_en0 = 1'b1;
    rdEn0 = 1'b1; address0 = 32'h1008;
    tick();
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) tick();
      if (c == 10) rdEn0 = 1'b0;
      checks++; if (ready0 !== (c == 8 || c >= 17)) begin errors++; $display("FAIL b2b_ready c%0d got %b", c, ready0); end
      if (c == 8 || c == 17) begin
        checks++; if (rd0 !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data c%0d got %h exp cafef00d", c, rd0); end
      end
      if (c == 9) begin
        checks++; if (sa0 !== 18'h0) begin errors++; $display("FAIL b2b_idle_addr got %h exp 0", sa0); end
      end
      if (c == 10 || c == 12) begin
        checks++; if (sa0 !== ((c == 10) ? 18'h604 : 18'h605)) begin errors++; $display("FAIL b2b_addr c%0d got %h", c, sa0); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    sram_en0 = 1'b1;
    rdEn0 = 1'b1; address0 = 32'h1000;
    tick();
    rdEn0 = 1'b0;
    tick(); tick(); tick();
    checks++; if (sa0 !== 18'h601 || ready0 !== 1'b0) begin errors++; $display("FAIL mrd_c4 got %h/%b exp 601/0", sa0, ready0); end
    rst = 1'b1;
    #1;
    checks++; if (sa0 !== 18'h0 || we0_n !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL mrd_rst got %h/%b/%b exp 0/1/0", sa0, we0_n, err0); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL mrd_rd got %h exp 0", rd0); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if ({ready0, err0, sa0} !== {2'b10, 18'h0}) begin errors++; $display("FAIL mrd_idle c%0d got %b/%b/%h", c, ready0, err0, sa0); end
    end
    rdEn0 = 1'b1; address0 = 32'h1000;
    tick();
    rdEn0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      checks++; if (ready0 !== (c == 8)) begin errors++; $display("FAIL mrd_follow_ready c%0d got %b", c, ready0); end
    end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL mrd_follow_data got %h exp deadbeef", rd0); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    sram_en0 = 1'b0;
    wrEn0 = 1'b1; address0 = 32'h1000; wd0 = 32'h55AA55AA;
    tick();
    wrEn0 = 1'b0;
    checks++; if (we0_n !== 1'b0) begin errors++; $display("FAIL mwr_we got %b exp 0", we0_n); end
    rst = 1'b1;
    #1;
    checks++; if (we0_n !== 1'b1 || dq0 !== 16'hA5A5) begin errors++; $display("FAIL mwr_rst got %b/%h exp 1/a5a5", we0_n, dq0); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({ready0, we0_n, err0} !== 3'b110 || rd0 !== 32'h0) begin errors++; $display("FAIL mwr_idle got %b rd %h", {ready0, we0_n, err0}, rd0); end
    checks++; if (mem0[12'h600] !== 16'hBEEF) begin errors++; $display("FAIL mwr_mem got %h exp beef", mem0[12'h600]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_default();
    test_read_default();
    test_wide64();
    test_reject();
    test_addr_boundary();
    test_priority();
    test_back_to_back();
    test_reset_mid_read();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_wide_controller.md
# sram_wide_controller

Parametrised successor to the single-word SRAM controller. It bridges the memory stage to the 16-bit off-chip SRAM. Each access moves a DATA_W-bit word as DATA_W/16 consecutive SRAM half-words. Request address and write data are latched at accept, the settle interval is configurable, read data is registered, and out-of-range or misaligned requests are rejected without touching the SRAM.

## Interface
- DATA_W, 32: CPU data width; one of 16, 32, 64. Derived: WORDS = DATA_W/16, BYTE_SH = log2(DATA_W/8), WSH = log2(WORDS).
- BASE_ADDR, 1024: CPU byte address mapped to SRAM half-word 0.
- SRAM_AW, 18: SRAM address width.
- SETTLE, 3: stall cycles after the last SRAM beat; range 1..15.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wrEn  in  1  write request, sampled in IDLE.
- rdEn  in  1  read request, sampled in IDLE. wrEn has priority when both are high.
- address  in  32  CPU byte address.
- writeData  in  DATA_W  write data.
- readData  out  DATA_W  data from the last successful read; registered.
- ready  out  1  high in IDLE with no request pending, and high for one cycle in DONE.
- err  out  1  high only in DONE, when the finished request was rejected.
- SRAM_DQ  inout  16  SRAM data bus; driven only in WRITE, otherwise Z.
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address.
- SRAM_WE_N  out  1  active-low write enable.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.

## Operation
- States: IDLE, WRITE, RADDR, RDATA, STALL, DONE. Support registers:
  - beat counter k, 0..WORDS-1
  - stall counter s
  - latched address aq and write data wq
  - error flag eq
- IDLE:
  - ready = ~(wrEn|rdEn); SRAM_WE_N=1; SRAM_ADDR=0.
  - On a request: latch aq, wq and the operation; set k=0, s=0.
  - Go to WRITE, RADDR or DONE (the rejected case).
- Reject condition, with off = address - BASE_ADDR:
  - address < BASE_ADDR, or
  - off[BYTE_SH-1:0] != 0, or
  - (off>>BYTE_SH) >= 2^(SRAM_AW-WSH).
  - A rejected request sets eq=1, goes straight to DONE, and leaves readData unchanged.
- Half-word address: SRAM_ADDR = {(aq-BASE_ADDR)>>BYTE_SH, k}, where k is WSH bits wide. Beat k carries writeData[16k+15:16k].
- WRITE:
  - SRAM_WE_N=0; SRAM_DQ = wq beat k.
  - If k==WORDS-1, go to STALL; otherwise k++ and stay.
- RADDR: present address beat k, then go to RDATA.
- RDATA:
  - Present the same address; capture SRAM_DQ into the internal shadow beat k at the clock edge.
  - If k==WORDS-1, go to STALL; otherwise k++ and go to RADDR.
- STALL: s++. When s==SETTLE-1, go to DONE.
- DONE:
  - ready=1; err=eq.
  - On a successful read, copy the shadow register to readData at the DONE-entry edge, so it is valid throughout DONE.
  - Next state is IDLE; clear eq.
- Request inputs are ignored outside IDLE. Changing address or writeData mid-access has no effect.

## Timing
- Reset values: state IDLE, readData=0, err=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, all counters 0.
  - While rst is high, ready follows the IDLE equation.
- Cycle 0 is the IDLE cycle in which the request is sampled.
  - Write: WRITE occupies cycles 1..WORDS, STALL the next SETTLE cycles, and ready pulses at cycle WORDS+SETTLE+1.
  - Read: RADDR/RDATA alternate over cycles 1..2·WORDS, and ready pulses at cycle 2·WORDS+SETTLE+1.
  - Reject: ready=1 and err=1 at cycle 1.
- Default configuration (DATA_W=32, SETTLE=3): write completes at cycle 6, read at cycle 8.
- After DONE the block returns to IDLE, so back-to-back requests cost one extra cycle. A request held high through DONE is accepted again in the following IDLE cycle.
- SRAM_DQ is released (Z) in every cycle except WRITE, so there is no bus contention in the WRITE→STALL turn-around.
- Reset mid-access: the next edge returns the block to IDLE.
  - SRAM_WE_N goes high and DQ goes Z in that same cycle.
  - No DONE pulse is produced, readData=0, and the partial shadow contents are discarded.

## Test plan
- Write, then read back, at default parameters: write 0x1000 with writeData=0xDEADBEEF.
  - SRAM_ADDR must be 0x600 with DQ=0xBEEF, then 0x601 with DQ=0xDEAD; WE_N low for exactly 2 cycles; ready at cycle 6.
  - A read of 0x1000 returns readData=0xDEADBEEF with ready at cycle 8.
- DATA_W=64, SETTLE=1: write 0x0123456789ABCDEF to address 1032.
  - Beats go to SRAM_ADDR 4,5,6,7 carrying 0xCDEF, 0x89AB, 0x4567, 0x0123; ready at cycle 6.
  - A read returns the same value with ready at cycle 10.
- Rejects:
  - address=1020 → err=1 and ready=1 at cycle 1, WE_N never low, readData unchanged.
  - address=1026 with DATA_W=32 (misaligned) → same response.
- wrEn=rdEn=1 together → write path taken. Changing address or writeData during the access does not alter the beats.
- Assert rst during the second RDATA of a read → IDLE after one edge, readData=0, no ready pulse. A following read completes normally.
